partition_err_monitor: RTL and testbench
========================================

Name: partition_err_monitor

Overview:
- Sequential stage directly downstream of an approximated BLASYS partition, e.g. an 8-in/5-out max_* partition.
- Sweeps every input vector exhaustively and drives it to both the exact and the approximate partition instances.
- Samples both output buses and accumulates error metrics in hardware: error count, Hamming-distance sum and worst-case absolute error.
- Replaces the print-and-diff flow for on-board or emulation-based error evaluation.

Parameters:
- IN_W, 8, partition input width; the sweep covers 0 to 2^IN_W-1.
- OUT_W, 5, partition output width.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a sweep.
- pi  output  IN_W  current stimulus vector, registered, fed to both partitions.
- po_exact  input  OUT_W  exact partition output; combinational response to pi.
- po_approx  input  OUT_W  approximate partition output; combinational response to pi.
- busy  output  1  high in SWEEP and DRAIN.
- done  output  1  high in DONE; held until the next start.
- err_cnt  output  IN_W+1  number of vectors with po_exact != po_approx.
- hd_sum  output  IN_W+$clog2(OUT_W+1)  sum of popcount(po_exact ^ po_approx).
- max_abs_err  output  OUT_W  largest |po_exact - po_approx|, both treated as unsigned (feature-gated).
- first_err_vec  output  IN_W  pi value of the first mismatch (feature-gated).

Behaviour:
- Reset, asynchronous and active-low: state=IDLE; pi, err_cnt, hd_sum, max_abs_err, first_err_vec, busy and done all 0.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE or DONE, start=1 at edge E0:
  - state becomes SWEEP; pi<=0.
  - All accumulators cleared; done<=0; first-error-seen flag cleared.
- SWEEP, each edge: compare the current pi's po_exact/po_approx, accumulate, then pi<=pi+1.
- SWEEP, edge where pi == 2^IN_W-1: compare that pi, then state becomes DONE and done<=1.
- Timing: done is set at edge E(2^IN_W); for IN_W=8 that is 256 cycles after start. All 2^IN_W vectors are compared exactly once.
- DRAIN: a one-cycle state reserved for a registered-DUT variant.
  - With combinational partitions, SWEEP goes directly to DONE and DRAIN is never entered.
  - busy includes DRAIN for forward compatibility.
- Per comparison:
  - mismatch → err_cnt += 1.
  - hd_sum += popcount(xor).
  - Widths are sized so nothing wraps: err_cnt max 2^IN_W, hd_sum max OUT_W·2^IN_W.
- pi does not wrap during a sweep. In DONE, pi holds 2^IN_W-1.
- start while busy is ignored. start in DONE restarts and clears all results.
- Reset mid-sweep aborts immediately to the reset values. No partial results are retained.
- Result outputs are stable whenever done=1.

Optional Feature:
- Macro: PARTITION_ERR_MONITOR_WCE_EN.
- Defined:
  - max_abs_err tracks the running maximum of |po_exact - po_approx| (unsigned subtract, magnitude in OUT_W bits).
  - first_err_vec latches pi on the first mismatch of the sweep; it stays 0 if there is no mismatch.
- Undefined: both outputs are tied to 0, and the subtractor/comparator logic is absent.

Decomposition:
- Package partition_err_pkg holds:
  - the state enum (IDLE, SWEEP, DRAIN, DONE);
  - default IN_W and OUT_W localparams;
  - a function computing the hd_sum width.
- Sub-module blasys_popcount: parameter W, input W bits, output $clog2(W+1) bits; purely combinational; instantiated once on the xor.

Test Plan:
- po_approx tied to po_exact; start pulse → done rises exactly 256 cycles later; err_cnt=0, hd_sum=0, max_abs_err=0, first_err_vec=0.
- po_approx = po_exact ^ 5'b00001 → err_cnt=256, hd_sum=256, max_abs_err=1, first_err_vec=8'h00.
- po_approx = ~po_exact → err_cnt=256, hd_sum=1280, max_abs_err=31, provided the exact model outputs 0 or 31 somewhere.
- Mismatch only at pi=8'hA5 with xor 5'b10100 → err_cnt=1, hd_sum=2, first_err_vec=8'hA5.
- Reset asserted when pi=8'h40 → all outputs 0 asynchronously and state IDLE; a new start completes with correct totals.
- start pulsed at pi=8'h10 → ignored, done still at cycle 256. start in DONE → done drops next cycle, accumulators zero, sweep repeats.

Source files
------------

// File: rtl/partition_err_pkg.sv
// partition_err_pkg: shared FSM state type, default widths and result-width helper
package partition_err_pkg;
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  localparam int DEF_IN_W = 8;
  localparam int DEF_OUT_W = 5;
  function automatic int hd_w(input int in_w, input int out_w);
    return in_w + $clog2(out_w + 1);
  endfunction
endpackage

// File: rtl/blasys_popcount.sv
// blasys_popcount: combinational count of set bits
//   a : W-bit input vector
//   n : number of ones in a
module blasys_popcount #(
  parameter int W = 5
) (
  input  logic [W-1:0]           a,
  output logic [$clog2(W+1)-1:0] n
);
  localparam int N = $clog2(W + 1);
  always_comb begin
    n = '0;
    for (int i = 0; i < W; i++) n = n + N'(a[i]);
  end
endmodule

// File: rtl/partition_err_monitor.sv
// partition_err_monitor: exhaustive sweep of a partition's inputs, accumulating exact-vs-approx error metrics
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : one-cycle pulse, begins (or restarts from DONE) a sweep
//   pi            : registered stimulus driven to both partitions
//   po_exact/po_approx : combinational partition responses to pi
//   busy, done    : sweep in progress / results valid and stable
//   err_cnt, hd_sum    : mismatching-vector count, summed Hamming distance
//   max_abs_err, first_err_vec : worst |exact-approx| and first mismatching pi,
//                  present only with PARTITION_ERR_MONITOR_WCE_EN defined, else 0
module partition_err_monitor
  import partition_err_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic [IN_W-1:0]               pi,
  input  logic [OUT_W-1:0]              po_exact,
  input  logic [OUT_W-1:0]              po_approx,
  output logic                          busy,
  output logic                          done,
  output logic [IN_W:0]                 err_cnt,
  output logic [hd_w(IN_W,OUT_W)-1:0]   hd_sum,
  output logic [OUT_W-1:0]              max_abs_err,
  output logic [IN_W-1:0]               first_err_vec
);
  localparam int HW = hd_w(IN_W, OUT_W);
  localparam int PW = $clog2(OUT_W + 1);
  state_t state, nxt;
  logic [OUT_W-1:0] x;
  logic [PW-1:0] pc;
  logic go, last, cmp;
  assign x    = po_exact ^ po_approx;
  assign go   = start && (state == IDLE || state == DONE);
  assign last = pi == '1;
  assign cmp  = state == SWEEP;
  blasys_popcount #(.W(OUT_W)) u_pc (.a(x), .n(pc));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = go ? SWEEP :
          (state == SWEEP && last) ? DONE :
          state == DRAIN ? DONE : state;
  always_comb begin
    busy = state == SWEEP || state == DRAIN;
    done = state == DONE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pi      <= '0;
      err_cnt <= '0;
      hd_sum  <= '0;
    end else if (go) begin
      pi      <= '0;
      err_cnt <= '0;
      hd_sum  <= '0;
    end else if (cmp) begin
      err_cnt <= err_cnt + (IN_W+1)'(|x);
      hd_sum  <= hd_sum + HW'(pc);
      if (!last) pi <= pi + 1'b1;
    end
`ifdef PARTITION_ERR_MONITOR_WCE_EN
  logic [OUT_W-1:0] ad;
  logic seen;
  always_comb ad = po_exact >= po_approx ? po_exact - po_approx : po_approx - po_exact;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      max_abs_err   <= '0;
      first_err_vec <= '0;
      seen          <= 1'b0;
    end else if (go) begin
      max_abs_err   <= '0;
      first_err_vec <= '0;
      seen          <= 1'b0;
    end else if (cmp && |x) begin
      if (ad > max_abs_err) max_abs_err <= ad;
      if (!seen) first_err_vec <= pi;
      seen <= 1'b1;
    end
`else
  assign max_abs_err   = '0;
  assign first_err_vec = '0;
`endif
endmodule

// File: tb/tb_partition_err_monitor.sv
// tb_partition_err_monitor: scoreboard bench for partition_err_monitor with a modelled exact/approx partition pair
module tb_partition_err_monitor;
`ifdef PARTITION_ERR_MONITOR_WCE_EN
  localparam bit WCE = 1'b1;
`else
  localparam bit WCE = 1'b0;
`endif
  typedef struct {
    int cyc;
    int err;
    int hd;
    int mx;
    int first;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [7:0] pi;
  logic [4:0] po_exact, po_approx;
  logic busy, done;
  logic [8:0] err_cnt;
  logic [10:0] hd_sum;
  logic [4:0] max_abs_err;
  logic [7:0] first_err_vec;
  int mode = 0;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  logic done_q = 1'b0;
  exp_t q[$];

  partition_err_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pi(pi),
    .po_exact(po_exact), .po_approx(po_approx), .busy(busy), .done(done),
    .err_cnt(err_cnt), .hd_sum(hd_sum), .max_abs_err(max_abs_err),
    .first_err_vec(first_err_vec)
  );

  always #5 clk = ~clk;

  // exact model is 0 at pi=0; approx model varies per scenario
  always_comb begin
    po_exact  = pi[4:0] ^ {2'b00, pi[7:5]};
    po_approx = mode == 1 ? po_exact ^ 5'b00001 :
                mode == 2 ? ~po_exact :
                (mode == 3 && pi == 8'hA5) ? po_exact ^ 5'b10100 : po_exact;
  end

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(posedge clk)
    if (start && !busy) cyc <= 0;
    else cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("done_latency", cyc, e.cyc);
        check("err_cnt", err_cnt, e.err);
        check("hd_sum", hd_sum, e.hd);
        check("max_abs_err", max_abs_err, e.mx);
        check("first_err_vec", first_err_vec, e.first);
      end
    end
    done_q <= done;
  end

  task automatic push(input int err, input int hd, input int mx, input int first);
    exp_t e;
    e.cyc = 256; e.err = err; e.hd = hd; e.mx = WCE ? mx : 0; e.first = WCE ? first : 0;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    if (!done) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run(input int m, input int err, input int hd, input int mx, input int first);
    mode = m;
    push(err, hd, mx, first);
    pulse_start();
    wait_done();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pi"}, pi, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_hd_sum"}, hd_sum, 0);
    check({tag, "_max_abs_err"}, max_abs_err, 0);
    check({tag, "_first_err_vec"}, first_err_vec, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run(0, 0, 0, 0, 0);
    run(1, 256, 256, 1, 0);
    run(2, 256, 1280, 31, 0);
    run(3, 1, 2, 20, 8'hA5);
    // start in DONE restarts and clears
    mode = 1;
    push(256, 256, 1, 0);
    pulse_start();
    check("restart_done_low", done, 0);
    check("restart_busy", busy, 1);
    check("restart_err_cnt", err_cnt, 0);
    check("restart_hd_sum", hd_sum, 0);
    check("restart_pi", pi, 0);
    wait_done();
    // start while busy is ignored
    mode = 0;
    push(0, 0, 0, 0);
    pulse_start();
    for (int i = 0; i < 300 && pi != 8'h10; i++) @(negedge clk);
    check("reach_pi_10", pi, 8'h10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // asynchronous reset mid-sweep
    mode = 2;
    pulse_start();
    for (int i = 0; i < 300 && pi != 8'h40; i++) @(negedge clk);
    check("reach_pi_40", pi, 8'h40);
    #2 rst_n = 1'b0;
    #1 check_zero("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    run(2, 256, 1280, 31, 0);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
